// File: rtl/velocity_cell_sequencer.sv
// velocity_cell_sequencer
//
// Drives one cell's single-port velocity RAM (96-bit {vz,vy,vx}; address 0 holds the particle
// count). A start pulse reads the count, streams words 1..count to the motion-update datapath
// through a 4-entry FIFO, and writes the updated words that come back into the same RAM.
//
// Ports:
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   start_i                    one-cycle pulse; ignored while a pass is running
//   busy_o, done_o, err_o      pass running / one-cycle end-of-pass / sticky error
//   ram_address_o, ram_data_o  registered RAM address and write data
//   ram_rden_o, ram_wren_o     registered RAM read / write enables
//   ram_q_i                    RAM read data, valid the cycle after ram_rden_o
//   out_valid_o/out_ready_i    streamed velocity handshake
//   out_data_o, out_pid_o      FIFO head: velocity and its RAM address
//   in_valid_i, in_data_i,     updated velocity write-back (never backpressured)
//   in_pid_i
module velocity_cell_sequencer #(
  parameter int unsigned DataWidth   = 96,
  parameter int unsigned ParticleNum = 220,
  parameter int unsigned AddrWidth   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [AddrWidth-1:0] ram_address_o,
  output logic [DataWidth-1:0] ram_data_o,
  output logic                 ram_rden_o,
  output logic                 ram_wren_o,
  input  logic [DataWidth-1:0] ram_q_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic [AddrWidth-1:0] out_pid_o,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic [AddrWidth-1:0] in_pid_i
);

  localparam int unsigned FifoDepth = 4;
  localparam int unsigned PtrWidth  = $clog2(FifoDepth);
  localparam logic [AddrWidth-1:0] MaxCount = AddrWidth'(ParticleNum - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdCnt,
    StWaitCnt,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Read pipeline: rd_part_q marks a particle read on the pins this cycle, ret_q marks its
  // data arriving on ram_q_i (pushed into the FIFO at the end of that cycle).
  logic                 rd_part_q, rd_part_d;
  logic                 ret_q, ret_d;
  logic [AddrWidth-1:0] ret_pid_q, ret_pid_d;

  logic [AddrWidth-1:0] count_q, count_d;
  logic [AddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic [AddrWidth-1:0] wb_cnt_q, wb_cnt_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [AddrWidth-1:0] ram_address_q, ram_address_d;
  logic [DataWidth-1:0] ram_data_q, ram_data_d;
  logic                 ram_rden_q, ram_rden_d;
  logic                 ram_wren_q, ram_wren_d;

  logic [DataWidth-1:0] fifo_data_q [FifoDepth];
  logic [AddrWidth-1:0] fifo_pid_q  [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrWidth:0]    fifo_cnt_q, fifo_cnt_d;

  logic                 start_acc;
  logic                 wb_fire;
  logic                 wb_zero;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [3:0]           pending;
  logic                 credit_ok;
  logic [AddrWidth-1:0] cnt_raw;
  logic                 cnt_clamp;
  logic [AddrWidth-1:0] cnt_eff;
  logic                 issue_part;
  logic                 issue_cnt;

  assign start_acc  = (state_q == StIdle) && start_i;
  assign wb_fire    = in_valid_i && (in_pid_i != '0);
  assign wb_zero    = in_valid_i && (in_pid_i == '0);
  assign push       = ret_q;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = !fifo_empty && out_ready_i;

  // Words already buffered plus words still on their way must leave room for one more.
  // A pop this cycle frees a slot before the newly issued read can land.
  assign pending    = 4'(fifo_cnt_q) + 4'(rd_part_q) + 4'(ret_q) - 4'(pop);
  assign credit_ok  = pending < 4'(FifoDepth);

  assign cnt_raw    = ram_q_i[AddrWidth-1:0];
  assign cnt_clamp  = cnt_raw > MaxCount;
  assign cnt_eff    = cnt_clamp ? MaxCount : cnt_raw;

  // ---------------------------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: next state and read-issue decisions. A read decided here appears on the pins next
  // cycle; a write-back arriving now claims that same pin cycle, so every issue yields to it.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    issue_part = 1'b0;
    issue_cnt  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StRdCnt;
          issue_cnt = !wb_fire;
        end
      end
      StRdCnt: begin
        // ram_rden_q here can only be the count read; otherwise it was displaced by a write.
        if (ram_rden_q) begin
          state_d = StWaitCnt;
        end else begin
          issue_cnt = !wb_fire;
        end
      end
      StWaitCnt: begin
        if (cnt_eff == '0) begin
          state_d = StDone;
        end else begin
          issue_part = !wb_fire;
          state_d    = (issue_part && (cnt_eff == AddrWidth'(1))) ? StDrain : StStream;
        end
      end
      StStream: begin
        issue_part = credit_ok && !wb_fire;
        if (issue_part && (rd_addr_q == count_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty && !rd_part_q && !ret_q && (wb_cnt_q == count_q)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // FSM: registered-output next values
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    ram_wren_d    = wb_fire;
    ram_rden_d    = issue_part || issue_cnt;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    if (wb_fire) begin
      ram_address_d = in_pid_i;
      ram_data_d    = in_data_i;
    end else if (issue_part) begin
      ram_address_d = rd_addr_q;
    end else if (issue_cnt) begin
      ram_address_d = '0;
    end
    busy_d = (state_d == StRdCnt) || (state_d == StWaitCnt) ||
             (state_d == StStream) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  // ---------------------------------------------------------------------------------------------
  // Counters, read pipeline and error flag
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    wb_cnt_d  = wb_cnt_q;
    err_d     = err_q;
    rd_part_d = issue_part;
    ret_d     = rd_part_q;
    ret_pid_d = ram_address_q;

    if (state_q == StWaitCnt) begin
      count_d = cnt_eff;
    end

    if (start_acc) begin
      rd_addr_d = AddrWidth'(1);
    end else if (issue_part) begin
      rd_addr_d = rd_addr_q + AddrWidth'(1);
    end

    if (start_acc) begin
      wb_cnt_d = '0;
    end else if (busy_q && wb_fire) begin
      wb_cnt_d = wb_cnt_q + AddrWidth'(1);
    end

    // A set in the same cycle as a clearing start wins.
    if (start_acc) begin
      err_d = 1'b0;
    end
    if (wb_zero || ((state_q == StWaitCnt) && cnt_clamp)) begin
      err_d = 1'b1;
    end

    fifo_cnt_d = fifo_cnt_q + (PtrWidth + 1)'(push) - (PtrWidth + 1)'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q       <= '0;
      rd_addr_q     <= '0;
      wb_cnt_q      <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_part_q     <= 1'b0;
      ret_q         <= 1'b0;
      ret_pid_q     <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_rden_q    <= 1'b0;
      ram_wren_q    <= 1'b0;
    end else begin
      count_q       <= count_d;
      rd_addr_q     <= rd_addr_d;
      wb_cnt_q      <= wb_cnt_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_part_q     <= rd_part_d;
      ret_q         <= ret_d;
      ret_pid_q     <= ret_pid_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_rden_q    <= ram_rden_d;
      ram_wren_q    <= ram_wren_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output FIFO: head entry drives the stream, so it holds while the consumer stalls.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pid_q[i]  <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_q_i;
        fifo_pid_q[wr_ptr_q]  <= ret_pid_q;
        wr_ptr_q              <= wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign out_valid_o   = !fifo_empty;
  assign out_data_o    = fifo_data_q[rd_ptr_q];
  assign out_pid_o     = fifo_pid_q[rd_ptr_q];

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign ram_address_o = ram_address_q;
  assign ram_data_o    = ram_data_q;
  assign ram_rden_o    = ram_rden_q;
  assign ram_wren_o    = ram_wren_q;

endmodule

// File: tb/tb_velocity_cell_sequencer.sv
module tb_velocity_cell_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, err;
  logic [7:0]  ram_address;
  logic [95:0] ram_data;
  logic        ram_rden, ram_wren;
  logic [95:0] ram_q = '0;
  logic        out_valid, out_ready;
  logic [95:0] out_data;
  logic [7:0]  out_pid;
  logic        in_valid;
  logic [95:0] in_data;
  logic [7:0]  in_pid;

  // manual write-back drive and echo drive
  logic        m_valid;
  logic [95:0] m_data;
  logic [7:0]  m_pid;
  logic        echo_en;
  logic        s1_v = 1'b0, e_v = 1'b0;
  logic [7:0]  s1_pid = '0, e_pid = '0;
  logic [95:0] s1_data = '0, e_data = '0;

  assign in_valid = echo_en ? e_v : m_valid;
  assign in_pid   = echo_en ? e_pid : m_pid;
  assign in_data  = echo_en ? e_data : m_data;

  // RAM model
  logic [95:0] mem [0:255];
  logic        ld_en;
  logic [7:0]  ld_cnt;
  int          ld_seed;

  // monitors
  int          acc_n = 0, rdn = 0, dn = 0, wn = 0, ovn = 0;
  logic [7:0]  acc_pid  [0:1023];
  logic [95:0] acc_data [0:1023];

  int checks = 0;
  int errors = 0;

  velocity_cell_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .ram_address_o(ram_address),
    .ram_data_o   (ram_data),
    .ram_rden_o   (ram_rden),
    .ram_wren_o   (ram_wren),
    .ram_q_i      (ram_q),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_pid_o    (out_pid),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_pid_i     (in_pid)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] pat(input int a, input int s);
    logic [31:0] b;
    b = 32'(a) + 32'(s) * 32'h100;
    return {32'h3000_0000 + b, 32'h2000_0000 + b, 32'h1000_0000 + b};
  endfunction

  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= (i == 0) ? 96'(ld_cnt) : pat(i, ld_seed);
      end
    end else begin
      if (ram_wren) mem[ram_address] <= ram_data;
      if (ram_rden) ram_q <= mem[ram_address];
    end
  end

  // echo each accepted word back +1 two cycles later; log accepts and events
  always @(posedge clk) begin
    s1_v    <= echo_en && out_valid && out_ready;
    s1_pid  <= out_pid;
    s1_data <= out_data + 96'd1;
    e_v     <= s1_v;
    e_pid   <= s1_pid;
    e_data  <= s1_data;
    if (out_valid && out_ready) begin
      acc_pid[acc_n[9:0]]  <= out_pid;
      acc_data[acc_n[9:0]] <= out_data;
      acc_n <= acc_n + 1;
    end
    if (ram_rden && ram_address != 8'd0) rdn <= rdn + 1;
    if (done) dn <= dn + 1;
    if (ram_wren) wn <= wn + 1;
    if (out_valid) ovn <= ovn + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] cnt, input int seed);
    ld_cnt  = cnt;
    ld_seed = seed;
    ld_en   = 1'b1;
    cyc();
    ld_en   = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      cyc();
      n++;
    end
    chk(tag, 128'(done), 128'(1));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_addr"}, 128'(ram_address), 128'(0));
    chk({tag, "_wdata"}, 128'(ram_data), 128'(0));
    chk({tag, "_rden"}, 128'(ram_rden), 128'(0));
    chk({tag, "_wren"}, 128'(ram_wren), 128'(0));
    chk({tag, "_ovalid"}, 128'(out_valid), 128'(0));
    chk({tag, "_odata"}, 128'(out_data), 128'(0));
    chk({tag, "_opid"}, 128'(out_pid), 128'(0));
  endtask

  initial begin
    int a0, d0, w0, o0, r0;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    m_valid = 1'b0; m_data = '0; m_pid = '0;
    echo_en = 1'b0; ld_en = 1'b0; ld_cnt = '0; ld_seed = 0;
    #1;
    chk_all_zero("reset");
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // ---- pass of 3 with echo ----
    load(8'd3, 1);
    echo_en = 1'b1; out_ready = 1'b1;
    d0 = dn;
    start = 1'b1; cyc();                       // cycle 1
    start = 1'b0;
    chk("t1_cnt_rden", 128'(ram_rden), 128'(1));
    chk("t1_cnt_addr", 128'(ram_address), 128'(0));
    chk("t1_busy", 128'(busy), 128'(1));
    cyc(); cyc();                              // cycle 3
    chk("t1_rd1_rden", 128'(ram_rden), 128'(1));
    chk("t1_rd1_addr", 128'(ram_address), 128'(1));
    cyc();
    chk("t1_c4_ovalid", 128'(out_valid), 128'(0));
    cyc();                                     // cycle 5
    chk("t1_c5_ovalid", 128'(out_valid), 128'(1));
    chk("t1_c5_pid", 128'(out_pid), 128'(1));
    chk("t1_c5_data", 128'(out_data), 128'(pat(1, 1)));
    cyc();
    chk("t1_c6_pid", 128'(out_pid), 128'(2));
    cyc();
    chk("t1_c7_pid", 128'(out_pid), 128'(3));
    chk("t1_c7_data", 128'(out_data), 128'(pat(3, 1)));
    cyc();                                     // cycle 8
    chk("t1_c8_ovalid", 128'(out_valid), 128'(0));
    chk("t1_c8_wren", 128'(ram_wren), 128'(1));
    chk("t1_c8_waddr", 128'(ram_address), 128'(1));
    chk("t1_c8_wdata", 128'(ram_data), 128'(pat(1, 1) + 96'd1));
    cyc(); cyc();
    chk("t1_c10_done", 128'(done), 128'(0));
    cyc();                                     // cycle 11
    chk("t1_done", 128'(done), 128'(1));
    chk("t1_busy_low", 128'(busy), 128'(0));
    cyc();
    chk("t1_done_pulse", 128'(done), 128'(0));
    chk("t1_mem1", 128'(mem[1]), 128'(pat(1, 1) + 96'd1));
    chk("t1_mem2", 128'(mem[2]), 128'(pat(2, 1) + 96'd1));
    chk("t1_mem3", 128'(mem[3]), 128'(pat(3, 1) + 96'd1));
    chk("t1_ndone", 128'(dn - d0), 128'(1));
    chk("t1_err", 128'(err), 128'(0));

    // ---- count 0 ----
    load(8'd0, 2);
    w0 = wn; o0 = ovn;
    start = 1'b1; cyc();
    start = 1'b0; cyc(); cyc();                // cycle 3
    chk("t2_done", 128'(done), 128'(1));
    chk("t2_busy", 128'(busy), 128'(0));
    cyc();
    chk("t2_done_pulse", 128'(done), 128'(0));
    chk("t2_no_ovalid", 128'(ovn - o0), 128'(0));
    chk("t2_no_wren", 128'(wn - w0), 128'(0));

    // ---- count 5 with stalled consumer ----
    load(8'd5, 3);
    out_ready = 1'b0;
    a0 = acc_n; r0 = rdn;
    start = 1'b1; cyc();
    start = 1'b0; cyc(); cyc(); cyc(); cyc();  // cycle 5
    chk("t3_c5_ovalid", 128'(out_valid), 128'(1));
    chk("t3_c5_pid", 128'(out_pid), 128'(1));
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t3_stall_data", 128'(out_data), 128'(pat(1, 3)));
      chk("t3_stall_pid", 128'(out_pid), 128'(1));
    end
    chk("t3_reads_buffered", 128'(rdn - r0), 128'(4));
    out_ready = 1'b1;
    wait_done(60, "t3_done");
    cyc();
    chk("t3_nacc", 128'(acc_n - a0), 128'(5));
    for (int i = 0; i < 5; i++) begin
      chk("t3_order_pid", 128'(acc_pid[a0 + i]), 128'(i + 1));
      chk("t3_order_data", 128'(acc_data[a0 + i]), 128'(pat(i + 1, 3)));
    end
    chk("t3_mem5", 128'(mem[5]), 128'(pat(5, 3) + 96'd1));

    // ---- write-back collides with first particle read ----
    load(8'd3, 4);
    echo_en = 1'b0;
    a0 = acc_n;
    start = 1'b1; cyc();
    start = 1'b0; cyc();                       // cycle 2
    m_valid = 1'b1; m_pid = 8'd100; m_data = 96'hABC;
    cyc();                                     // cycle 3
    m_valid = 1'b0;
    chk("t4_wren", 128'(ram_wren), 128'(1));
    chk("t4_waddr", 128'(ram_address), 128'(100));
    chk("t4_wdata", 128'(ram_data), 128'(96'hABC));
    chk("t4_rden_stalled", 128'(ram_rden), 128'(0));
    cyc();
    chk("t4_rd1_rden", 128'(ram_rden), 128'(1));
    chk("t4_rd1_addr", 128'(ram_address), 128'(1));
    cyc();
    chk("t4_rd2_addr", 128'(ram_address), 128'(2));
    cyc();                                     // cycle 6
    chk("t4_c6_pid", 128'(out_pid), 128'(1));
    cyc();
    chk("t4_c7_pid", 128'(out_pid), 128'(2));
    cyc();
    chk("t4_c8_pid", 128'(out_pid), 128'(3));
    chk("t4_c8_data", 128'(out_data), 128'(pat(3, 4)));
    chk("t4_mem100", 128'(mem[100]), 128'(96'hABC));
    rst_n = 1'b0; cyc();
    rst_n = 1'b1; cyc();

    // ---- count clamp ----
    load(8'd250, 5);
    echo_en = 1'b1; out_ready = 1'b1;
    a0 = acc_n;
    start = 1'b1; cyc();
    start = 1'b0; cyc();
    chk("t5_c2_err", 128'(err), 128'(0));
    cyc();
    chk("t5_err", 128'(err), 128'(1));
    wait_done(900, "t5_done");
    cyc();
    chk("t5_nacc", 128'(acc_n - a0), 128'(219));
    chk("t5_last_pid", 128'(acc_pid[acc_n - 1]), 128'(219));
    chk("t5_mem219", 128'(mem[219]), 128'(pat(219, 5) + 96'd1));
    chk("t5_mem220", 128'(mem[220]), 128'(pat(220, 5)));
    chk("t5_err_sticky", 128'(err), 128'(1));

    // ---- start clears err; write-back to address 0 ----
    load(8'd0, 6);
    echo_en = 1'b0;
    start = 1'b1; cyc();
    start = 1'b0;
    chk("t5b_err_cleared", 128'(err), 128'(0));
    cyc(); cyc(); cyc();                       // cycle 4, idle
    w0 = wn;
    m_valid = 1'b1; m_pid = 8'd0; m_data = 96'h5555;
    cyc();
    m_valid = 1'b0;
    chk("t5b_pid0_wren", 128'(ram_wren), 128'(0));
    chk("t5b_pid0_err", 128'(err), 128'(1));
    cyc();
    chk("t5b_pid0_nowrite", 128'(wn - w0), 128'(0));
    chk("t5b_mem0", 128'(mem[0]), 128'(0));

    // ---- reset mid-stream, then a clean pass ----
    load(8'd5, 7);
    echo_en = 1'b1; out_ready = 1'b0;
    start = 1'b1; cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();         // cycle 6
    chk("t6_busy_before", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    cyc();
    rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;
    a0 = acc_n;
    start = 1'b1; cyc();
    start = 1'b0;
    wait_done(60, "t6_done");
    cyc();
    chk("t6_nacc", 128'(acc_n - a0), 128'(5));
    for (int i = 0; i < 5; i++) begin
      chk("t6_order_pid", 128'(acc_pid[a0 + i]), 128'(i + 1));
    end
    chk("t6_mem3", 128'(mem[3]), 128'(pat(3, 7) + 96'd1));
    chk("t6_err", 128'(err), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/velocity_cell_sequencer.md
# velocity_cell_sequencer

Sequencer sitting directly upstream of one cell's velocity RAM (single-port, 96-bit {vz,vy,vx}, address 0 holds the particle count). On a start pulse it reads the count, streams each particle's velocity to the motion-update datapath over a valid/ready interface, and writes the updated velocities that return back into the same RAM. It owns the RAM's address, data, rden and wren pins exclusively and signals completion once every streamed particle has been written back.

## Interface
- DATA_WIDTH, 96, velocity word width {vz,vy,vx}, 32 bits each
- PARTICLE_NUM, 220, RAM depth, including address 0
- ADDR_WIDTH, 8, RAM address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a pass, ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of a pass
- err  out  1  sticky; set on count clamp or on a write-back to address 0; cleared by start
- ram_address  out  ADDR_WIDTH  RAM address (registered)
- ram_data  out  DATA_WIDTH  RAM write data (registered)
- ram_rden  out  1  RAM read enable (registered)
- ram_wren  out  1  RAM write enable (registered)
- ram_q  in  DATA_WIDTH  RAM read data, valid the cycle after ram_rden
- out_valid  out  1  streamed velocity valid
- out_ready  in  1  downstream accepts when out_valid and out_ready
- out_data  out  DATA_WIDTH  velocity {vz,vy,vx}
- out_pid  out  ADDR_WIDTH  RAM address of out_data (1..count)
- in_valid  in  1  updated velocity valid; no backpressure, always accepted
- in_data  in  DATA_WIDTH  updated velocity
- in_pid  in  ADDR_WIDTH  target address

## Operation
- Reset: all outputs 0; FSM in IDLE; FIFO empty; all counters 0.
- FSM states:
  - IDLE: accepted start -> RD_CNT; clears err.
  - RD_CNT: issue a read of address 0 -> WAIT_CNT.
  - WAIT_CNT: latch ram_q[ADDR_WIDTH-1:0] as count. If count > PARTICLE_NUM-1, clamp it to PARTICLE_NUM-1 and set err. count==0 -> DONE; otherwise -> STREAM.
  - STREAM: issue reads of addresses 1..count in order -> DRAIN after the last read is issued.
  - DRAIN: wait until the FIFO is empty and wb_cnt==count -> DONE.
  - DONE: assert done for 1 cycle -> IDLE.
- Read issue: a read is issued only if fifo_occupancy + reads_in_flight < 4. Returning data is pushed into a 4-entry FIFO together with its address.
- Output: out_data and out_pid come from the FIFO head; out_valid = FIFO not empty.
- Output stability: while out_valid && !out_ready, out_data and out_pid hold stable.
- Write-back: in_valid at cycle t drives ram_wren=1, ram_address=in_pid and ram_data=in_data at cycle t+1.
- Port conflict: a write always wins the single port. A read that would issue in the same cycle stalls one cycle.
- Write-back counting: wb_cnt increments on each in_valid while busy.
- Address 0 protection: in_pid==0 is dropped (no wren), sets err, and is not counted.
- Write-backs in IDLE are performed but not counted.
- Counter widths: ADDR_WIDTH bits. Address increment never exceeds count, so there is no wrap-around.
- Reset mid-pass: everything returns to the reset state immediately; in-flight reads and FIFO contents are discarded.

## Timing
- A read issued at cycle t (ram_rden=1) returns data on ram_q at t+1, which is pushed into the FIFO at the end of t+1. out_valid rises at t+2.
- start at cycle 0: ram_rden=1 with address 0 at cycle 1; count latched at cycle 2; first particle read at cycle 3; first out_valid at cycle 5.
- Throughput with out_ready held high and no write-backs: 1 particle per cycle.
- done fires 1 cycle after the last condition (FIFO empty and wb_cnt==count) is met. busy falls in the same cycle done rises.
- count==0: done at cycle 3, with no out_valid.

## Test plan
- RAM[0]=3, velocities A,B,C at addresses 1-3, out_ready=1, each streamed word echoed back +1 after 2 cycles -> out_pid 1,2,3 on consecutive cycles; RAM[1..3]=A+1,B+1,C+1; one done pulse; err=0.
- RAM[0]=0, start -> done at cycle 3; out_valid never high; no RAM writes.
- RAM[0]=5, out_ready low for 10 cycles then high -> at most 4 particles buffered; out_data stable while stalled; all 5 delivered in order with no duplicates.
- in_valid held on the cycle a read is due -> ram_wren takes the port, the read is delayed exactly 1 cycle, and the stream order is unchanged.
- RAM[0]=250 (PARTICLE_NUM=220) -> count clamped to 219; err=1; out_pid ends at 219. Separately, a write-back with in_pid=0 -> no write, err=1.
- rst_n low mid-STREAM -> all outputs 0 asynchronously; after release, start runs a clean full pass.
